// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, dump FSM states and well-known register indices
package regfile_pkg;
   localparam int RF_ADDRESS_WIDTH = 5;
   localparam int RF_DATA_WIDTH    = 32;
   localparam logic [RF_ADDRESS_WIDTH-1:0] A0_ADDR = 5'd10;
   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready stream of (index, data) beats from the dumper
interface regfile_dump_if import regfile_pkg::*; #(
   parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = RF_DATA_WIDTH
);
   logic                     valid;
   logic                     ready;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0]    data;
   modport master (output valid, addr, data, input ready);
   modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: sweeps a regfile index range through one read port and streams each value out
module regfile_dump import regfile_pkg::*; #(
   parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = RF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] first_addr,
   input  logic [ADDRESS_WIDTH-1:0] last_addr,
   output logic [ADDRESS_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0]    rf_data,
   regfile_dump_if.master           dump,
   output logic                     busy,
   output logic                     done
);
   dump_state_t              state, state_n;
   logic [ADDRESS_WIDTH-1:0] last_q;
   logic                     hs;
   assign hs   = dump.valid && dump.ready;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = start ? READ : IDLE;
         READ: state_n = SEND;
         SEND: state_n = hs ? ((rf_addr == last_q) ? DONE : READ) : SEND;
         DONE: state_n = IDLE;
      endcase
   end
   // rf_addr doubles as the sweep counter; it wraps naturally at 2**ADDRESS_WIDTH
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rf_addr    <= '0;
         last_q     <= '0;
         dump.valid <= 1'b0;
         dump.addr  <= '0;
         dump.data  <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            rf_addr <= first_addr;
            last_q  <= last_addr;
         end
         if (state == READ) begin
            dump.valid <= 1'b1;
            dump.addr  <= rf_addr;
            dump.data  <= rf_data;
         end
         if (state == SEND && hs) begin
            dump.valid <= 1'b0;
            if (rf_addr != last_q) rf_addr <= rf_addr + 1'b1;
         end
      end
   end
endmodule
